branch_unit: RTL

Parametrised branch/flow-control unit for the kitchen script processor. It replaces the two-mode conditional jump with a single-cycle-decision unit supporting conditional and unconditional jumps, wait-until stalls with timeout escape, and call/return through a bounded return stack. It sits between instruction decode (`en`, `func`, `i_num`, `i_sign`, `current_pc`) and the PC register (`next_pc`, `pc_valid`), and samples kitchen feedback directly.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_unit_if.sv | 29 ++
 rtl/branch_stack.sv | 39 +++
 rtl/branch_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the kitchen script branch unit:
// function codes, feedback signal indices and FSM encoding.
package branch_pkg;

    typedef enum logic [2:0] {
        F_JIF   = 3'b000,
        F_JIFN  = 3'b001,
        F_JMP   = 3'b010,
        F_WAIT  = 3'b011,
        F_WAITN = 3'b100,
        F_CALL  = 3'b101,
        F_RET   = 3'b110,
        F_NOP   = 3'b111
    } func_e;

    localparam int SIG_PLAYER_READY   = 0;
    localparam int SIG_PLAYER_HASITEM = 1;
    localparam int SIG_TARGET_READY   = 2;
    localparam int SIG_TARGET_HASITEM = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Decode/PC-register side bundle of the branch unit.
interface branch_unit_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 8,
    parameter int SIG_N = 8,
    parameter int SEL_W = 3
);
    logic             en;
    logic [2:0]       func;
    logic [OFF_W-1:0] i_num;
    logic [SEL_W-1:0] i_sign;
    logic [PC_W-1:0]  current_pc;
    logic [SIG_N-1:0] feedback_sig;
    logic [PC_W-1:0]  next_pc;
    logic             pc_valid;
    logic             busy;
    logic             timeout;
    logic             stack_err;

    modport master (
        output en, func, i_num, i_sign, current_pc, feedback_sig,
        input  next_pc, pc_valid, busy, timeout, stack_err
    );

    modport slave (
        input  en, func, i_num, i_sign, current_pc, feedback_sig,
        output next_pc, pc_valid, busy, timeout, stack_err
    );
endinterface

// File: rtl/branch_stack.sv
// Bounded LIFO of return addresses with synchronous reset.
module branch_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  mem [2**CW];

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign top   = empty ? '0 : mem[cnt - CW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt] <= din;
        end
    end
endmodule

// File: rtl/branch_unit.sv
// Single-cycle branch decision unit: jumps, wait-until with
// timeout escape, and call/return through a bounded stack.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int OFF_W       = 8,
    parameter int SIG_N       = 8,
    parameter int SEL_W       = 3,
    parameter int SIG_BASE    = 2,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic          clk,
    input logic          rst,
    branch_unit_if.slave bus
);
    localparam int SW    = PC_W + OFF_W + 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Indices past the top of feedback_sig shift out to zero.
    function automatic logic pick(
        input logic [SIG_N-1:0] fs,
        input logic [SEL_W-1:0] s
    );
        logic [SIG_N-1:0] sh;
        sh = fs >> (SIG_BASE + int'(s));
        return sh[0];
    endfunction

    state_e           state, state_n;
    func_e            f;
    logic [PC_W-1:0]  seq, tgt, l_seq, l_tgt, top, pc_n;
    logic [SEL_W-1:0] l_sel;
    logic             l_neg;
    logic [CNT_W-1:0] cnt;
    logic             sig, imm_met, w_met, at_limit;
    logic             push, pop, full, empty;
    logic             valid_n, to_n, err_set, latch;

    assign f        = func_e'(bus.func);
    assign seq      = PC_W'(SW'(bus.current_pc) + SW'(2));
    assign tgt      = PC_W'(SW'(bus.current_pc) + (SW'(bus.i_num) << 1));
    assign sig      = pick(bus.feedback_sig, bus.i_sign);
    assign imm_met  = sig ^ (f == F_WAITN);
    assign w_met    = pick(bus.feedback_sig, l_sel) ^ l_neg;
    assign at_limit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign bus.busy = (state == S_WAIT);

    branch_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .top   (top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.next_pc   <= '0;
            bus.pc_valid  <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.stack_err <= 1'b0;
            cnt           <= '0;
            l_seq         <= '0;
            l_tgt         <= '0;
            l_sel         <= '0;
            l_neg         <= 1'b0;
        end else begin
            state        <= state_n;
            bus.next_pc  <= pc_n;
            bus.pc_valid <= valid_n;
            bus.timeout  <= to_n;
            if (err_set) begin
                bus.stack_err <= 1'b1;
            end
            if (latch) begin
                l_seq <= seq;
                l_tgt <= tgt;
                l_sel <= bus.i_sign;
                l_neg <= (f == F_WAITN);
                cnt   <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (bus.en && (f == F_WAIT || f == F_WAITN) && !imm_met) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_met || at_limit) begin
                    state_n = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        pc_n    = bus.next_pc;
        valid_n = 1'b0;
        to_n    = 1'b0;
        err_set = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        latch   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!bus.en) begin
                    pc_n = bus.current_pc;
                end else begin
                    valid_n = 1'b1;
                    unique case (f)
                        F_JIF:  pc_n = sig ? tgt : seq;
                        F_JIFN: pc_n = sig ? seq : tgt;
                        F_JMP:  pc_n = tgt;
                        F_NOP:  pc_n = seq;
                        F_CALL: begin
                            push    = !full;
                            err_set = full;
                            pc_n    = full ? seq : tgt;
                        end
                        F_RET: begin
                            pop     = !empty;
                            err_set = empty;
                            pc_n    = empty ? seq : top;
                        end
                        F_WAIT, F_WAITN: begin
                            if (imm_met) begin
                                pc_n = seq;
                            end else begin
                                valid_n = 1'b0;
                                latch   = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_WAIT: begin
                // A condition met on the final cycle beats the timeout.
                if (w_met) begin
                    pc_n    = l_seq;
                    valid_n = 1'b1;
                end else if (at_limit) begin
                    pc_n    = l_tgt;
                    valid_n = 1'b1;
                    to_n    = 1'b1;
                end
            end
        endcase
    end
endmodule
